// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver, LSB first, with a two-flop input synchroniser and a valid/ready
// byte handshake that reports framing errors and overruns as single-cycle pulses.
module uart_rx_8n1 #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t           state;
    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             deliver;
    logic             rx_s;

    assign rx_s = sync[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync        <= 2'b11;
            state       <= S_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            deliver     <= 1'b0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            sync        <= {sync[0], rx_i};
            deliver     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;

            // Delivery happens one edge after a good stop sample; a same-cycle accept makes room.
            if (deliver) begin
                if (!valid_o || ready_i) begin
                    data_o  <= shreg;
                    valid_o <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state  <= S_START;
                        cnt    <= '0;
                        busy_o <= 1'b1;
                    end
                end
                S_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                        end else begin
                            state  <= S_IDLE;
                            busy_o <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt            <= '0;
                        shreg[bit_idx] <= rx_s;
                        bit_idx        <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            deliver <= 1'b1;
                            state   <= S_IDLE;
                            busy_o  <= 1'b0;
                        end else begin
                            frame_err_o <= 1'b1;
                            state       <= S_WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT_IDLE: begin
                    // A held-low break must end before another start edge can count.
                    if (rx_s) begin
                        state  <= S_IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Directed and randomized checks of uart_rx_8n1 with CLKS_PER_BIT=16 against a queue-based
// model of the received byte stream.
module tb_uart_rx_8n1;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
    localparam int TCLK = 100;
    localparam int BIT  = CPB * TCLK;
    localparam int LAT  = 2 + HALF + 9 * CPB + 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;

    uart_rx_8n1 #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .busy_o      (busy_o)
    );

    always #(TCLK / 2) clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Observers: cycle count, accepted bytes, and event counters.
    int         cyc   = 0;
    int         vhigh = 0;
    int         ferr  = 0;
    int         ovr   = 0;
    int         rise  = -1;
    logic       vprev = 1'b0;
    logic [7:0] acc[$];

    always @(posedge clk) begin
        cyc++;
        if (valid_o === 1'b1 && ready_i === 1'b1) acc.push_back(data_o);
    end

    always @(negedge clk) begin
        if (valid_o === 1'b1) vhigh++;
        if (valid_o === 1'b1 && vprev !== 1'b1) rise = cyc;
        vprev = valid_o;
        if (frame_err_o === 1'b1) ferr++;
        if (overrun_o === 1'b1) ovr++;
    end

    initial begin
        #(3_000_000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic align(output int c);
        @(posedge clk);
        #1;
        c = cyc;
    endtask

    task automatic send_frame(input logic [7:0] b, input int per, input logic stop);
        rx_i = 1'b0;
        #(per);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            #(per);
        end
        rx_i = stop;
        #(per);
    endtask

    task automatic wait_valid(input int maxc, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < maxc && !ok; i++) begin
            @(negedge clk);
            ok = (valid_o === 1'b1);
        end
    endtask

    initial begin
        int         c0;
        int         v0;
        int         f0;
        int         o0;
        int         a0;
        logic       ok;
        logic [7:0] b;
        int         per;
        logic [7:0] seq3[3];
        logic [7:0] exp_q[$];

        seq3  = '{8'h00, 8'hFF, 8'h55};
        reset = 1'b1;
        rx_i  = 1'b1;
        ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_data", 32'(data_o), 32'h00);
        check("rst_valid", 32'(valid_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_flags", 32'({frame_err_o, overrun_o}), 0);

        // Single byte with consumer always ready.
        ready_i = 1'b1;
        v0 = vhigh; f0 = ferr; o0 = ovr; a0 = acc.size(); rise = -1;
        align(c0);
        send_frame(8'hA5, BIT, 1'b1);
        repeat (10) @(negedge clk);
        check("single_latency", 32'((rise - c0) >= LAT - 1 && (rise - c0) <= LAT + 1), 1);
        check("single_valid_cycles", 32'(vhigh - v0), 1);
        check("single_count", 32'(acc.size() - a0), 1);
        check("single_data", 32'(acc[$]), 32'hA5);
        check("single_flags", 32'((ferr - f0) + (ovr - o0)), 0);

        // Back-to-back frames, consumer pulses ready after each valid.
        ready_i = 1'b0;
        f0 = ferr; o0 = ovr;
        align(c0);
        fork
            begin
                for (int k = 0; k < 3; k++) send_frame(seq3[k], BIT, 1'b1);
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    wait_valid(400, ok);
                    check("b2b_timeout", 32'(ok), 1);
                    check("b2b_data", 32'(data_o), 32'(seq3[k]));
                    ready_i = 1'b1;
                    @(negedge clk);
                    ready_i = 1'b0;
                    check("b2b_cleared", 32'(valid_o), 0);
                end
            end
        join
        repeat (5) @(negedge clk);
        check("b2b_flags", 32'((ferr - f0) + (ovr - o0)), 0);

        // Short low glitch must be rejected silently.
        v0 = vhigh; f0 = ferr; o0 = ovr;
        align(c0);
        rx_i = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch_busy_seen", 32'(busy_o), 1);
        repeat (2) @(posedge clk);
        #1 rx_i = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_busy_idle", 32'(busy_o), 0);
        check("glitch_no_valid", 32'(vhigh - v0), 0);
        check("glitch_flags", 32'((ferr - f0) + (ovr - o0)), 0);

        // Framing error followed by a long break, then a clean byte.
        ready_i = 1'b1;
        v0 = vhigh; f0 = ferr; o0 = ovr; a0 = acc.size();
        align(c0);
        send_frame(8'h3C, BIT, 1'b0);
        #(40 * BIT);
        check("break_busy", 32'(busy_o), 1);
        check("break_ferr_once", 32'(ferr - f0), 1);
        check("break_no_valid", 32'(vhigh - v0), 0);
        rx_i = 1'b1;
        repeat (5) @(negedge clk);
        check("break_released", 32'(busy_o), 0);
        align(c0);
        send_frame(8'h81, BIT, 1'b1);
        repeat (10) @(negedge clk);
        check("after_break_count", 32'(acc.size() - a0), 1);
        check("after_break_data", 32'(acc[$]), 32'h81);
        check("after_break_ferr", 32'(ferr - f0), 1);

        // Overrun: second byte dropped while the first is unaccepted.
        ready_i = 1'b0;
        f0 = ferr; o0 = ovr;
        align(c0);
        send_frame(8'h11, BIT, 1'b1);
        repeat (5) @(negedge clk);
        check("ovr_first_valid", 32'(valid_o), 1);
        check("ovr_first_data", 32'(data_o), 32'h11);
        align(c0);
        send_frame(8'h22, BIT, 1'b1);
        repeat (5) @(negedge clk);
        check("ovr_pulse_once", 32'(ovr - o0), 1);
        check("ovr_data_held", 32'(data_o), 32'h11);
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        check("ovr_ready_clears", 32'(valid_o), 0);
        align(c0);
        send_frame(8'h44, BIT, 1'b1);
        repeat (5) @(negedge clk);
        check("ovr_hold_data", 32'(data_o), 32'h44);
        // Accept exactly in the completion cycle of the next byte.
        align(c0);
        fork
            send_frame(8'h33, BIT, 1'b1);
            begin
                repeat (LAT - 1) @(posedge clk);
                #1 ready_i = 1'b1;
                @(posedge clk);
                #1 ready_i = 1'b0;
                check("same_cycle_valid", 32'(valid_o), 1);
                check("same_cycle_data", 32'(data_o), 32'h33);
            end
        join
        repeat (5) @(negedge clk);
        check("same_cycle_no_ovr", 32'(ovr - o0), 1);
        check("ovr_no_ferr", 32'(ferr - f0), 0);

        // Reset in the middle of data bit 4, with byte 0x33 still pending.
        f0 = ferr; o0 = ovr;
        b = 8'hC3;
        align(c0);
        rx_i = 1'b0;
        #(BIT);
        for (int i = 0; i < 4; i++) begin
            rx_i = b[i];
            #(BIT);
        end
        rx_i = b[4];
        #(BIT / 2);
        check("pre_reset_busy", 32'(busy_o), 1);
        reset = 1'b1;
        rx_i  = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_data", 32'(data_o), 32'h00);
        check("midrst_valid", 32'(valid_o), 0);
        check("midrst_busy", 32'(busy_o), 0);
        check("midrst_flags", 32'({frame_err_o, overrun_o}), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (20) @(negedge clk);
        check("midrst_idle", 32'(busy_o), 0);
        ready_i = 1'b1;
        a0 = acc.size();
        align(c0);
        send_frame(8'h7E, BIT, 1'b1);
        repeat (10) @(negedge clk);
        check("midrst_next_count", 32'(acc.size() - a0), 1);
        check("midrst_next_data", 32'(acc[$]), 32'h7E);
        check("midrst_no_flags", 32'((ferr - f0) + (ovr - o0)), 0);

        // Random bytes with bit period jittered within +-2.5% and random idle gaps.
        ready_i = 1'b1;
        f0 = ferr; o0 = ovr; a0 = acc.size();
        for (int n = 0; n < 8; n++) begin
            b   = 8'($urandom);
            per = BIT - 40 + int'($urandom_range(0, 80));
            align(c0);
            send_frame(b, per, 1'b1);
            exp_q.push_back(b);
            #($urandom_range(0, 2000));
        end
        repeat (20) @(negedge clk);
        check("rand_count", 32'(acc.size() - a0), 32'(exp_q.size()));
        for (int n = 0; n < exp_q.size() && a0 + n < acc.size(); n++) begin
            check($sformatf("rand_byte%0d", n), 32'(acc[a0 + n]), 32'(exp_q[n]));
        end
        check("rand_flags", 32'((ferr - f0) + (ovr - o0)), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_8n1.md
Name: uart_rx_8n1

Overview:
- UART receiver, 8N1 framing, LSB first. It is the counterpart to the chip's uart_tx output (uo_out[0]).
- Sits in the FPGA harness and on the bench. It captures the byte stream emitted by the TT design so that ring-oscillator/TRNG output can be checked and logged.
- Delivers each byte over a valid/ready handshake, with framing-error and overrun flags.

Parameters:
- CLKS_PER_BIT, 104, clock cycles per UART bit (12 MHz / 115200). Legal range ≥ 4.
- HALF_BIT, CLKS_PER_BIT/2, cycles from the detected start edge to the start-bit midpoint sample.

Ports:
- clk  in  1  system clock, single clock domain.
- reset  in  1  synchronous, active-high reset.
- rx_i  in  1  asynchronous serial line, idle high.
- data_o  out  8  received byte, stable while valid_o=1.
- valid_o  out  1  byte available; held until accepted.
- ready_i  in  1  consumer accepts the byte when valid_o && ready_i at a rising edge.
- frame_err_o  out  1  one-cycle pulse: stop bit sampled low.
- overrun_o  out  1  one-cycle pulse: a byte completed while the previous byte was still unaccepted.
- busy_o  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port reset.
- Input sync: rx_i passes through 2 flops to give rx_s. Both flops reset to 1. All decisions use rx_s only.
- Reset values: data_o=0x00, valid_o=0, frame_err_o=0, overrun_o=0, busy_o=0, FSM=IDLE, counters=0.
- Reset applied mid-frame aborts the frame. No flags fire. The next frame requires a fresh falling edge.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: when rx_s=0, go to START with cnt=0.
- START: count to HALF_BIT-1, then sample rx_s.
  - Sample 0: go to DATA with cnt=0, bit_idx=0.
  - Sample 1: treat as a glitch; return to IDLE silently, no flag.
- DATA: count to CLKS_PER_BIT-1, then shift rx_s into shreg[bit_idx] (LSB first) and reset cnt. After bit_idx=7, go to STOP.
- STOP: count to CLKS_PER_BIT-1, then sample rx_s.
  - Sample 1: deliver shreg, go to IDLE.
  - Sample 0: pulse frame_err_o for 1 cycle, discard the byte, go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s=1, then go to IDLE. A held-low break never retriggers reception.
- Counters: cnt is wide enough for CLKS_PER_BIT-1 and wraps to 0 at each bit sample. bit_idx is 3 bits.
- Delivery, registered on the edge after the stop sample:
  - valid_o=0: data_o<=shreg, valid_o<=1.
  - valid_o=1 and ready_i=1 in the same cycle: data_o<=shreg, valid_o stays 1, no overrun.
  - valid_o=1 and ready_i=0: new byte dropped, data_o unchanged, overrun_o pulses 1 cycle.
- Handshake: valid_o && ready_i clears valid_o on the next edge unless a new byte is being delivered in that same cycle. ready_i is ignored while valid_o=0. data_o is held constant while valid_o=1.
- Latency: valid_o rises 2 (sync) + HALF_BIT + 9*CLKS_PER_BIT + 2 cycles after the rx_i falling edge. Benches allow ±1 cycle.
- Tolerance: a frame whose bit period is within ±3% of CLKS_PER_BIT must be received correctly.
- busy_o: 1 in START/DATA/STOP/WAIT_IDLE. It is independent of valid_o.

Test Plan:
- Single byte: CLKS_PER_BIT=16, send 0xA5 with ready_i=1. Response: valid_o for exactly 1 cycle, data_o=0xA5, no flags, latency within ±1 of 2+8+144+2=156 cycles.
- Back-to-back bytes: send 0x00, 0xFF, 0x55 with no idle gap, ready_i held 0 until each valid_o, then pulsed. Response: three bytes in order, frame_err_o=0, overrun_o=0.
- Glitch rejection: 5-cycle low pulse on rx_i (< HALF_BIT), then idle. Response: busy_o returns 0, valid_o never asserts, no flags.
- Framing error and break: send 0x3C with the stop bit low, then hold rx_i low for 40 bit times, then release. Response: frame_err_o pulses once, valid_o=0, no new frame starts until rx_i goes high; a following 0x81 is received correctly.
- Overrun: ready_i=0, send 0x11 then 0x22. Response: overrun_o pulses once at the second stop sample, data_o stays 0x11. Raising ready_i clears valid_o. With ready_i=1 exactly on the completion cycle of a third byte 0x33: data_o=0x33, valid_o remains 1, no overrun.
- Reset mid-frame: assert reset during DATA bit 4 of 0xC3, then send 0x7E. Response: all outputs reset values immediately after reset, no flags, 0x7E received cleanly.
